// File: rtl/rca_seq.sv
// Multi-cycle ripple-carry adder: one CHUNK-bit slice per clock, carry registered between slices.
// Optional subtract mode via `define RCA_SEQ_SUB_EN (adds the 'sub' input port).
module rca_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef RCA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_sum;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK:0]   w_slice;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_init;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == ADD);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == CW'(NCHUNK - 1));

  // Subtraction is folded into the adder as a + ~b + 1, chosen at acceptance.
`ifdef RCA_SEQ_SUB_EN
  assign w_b_in   = sub ? ~b : b;
  assign w_c_init = sub ? 1'b1 : c_in;
`else
  assign w_b_in   = b;
  assign w_c_init = c_in;
`endif

  always_comb begin
    w_slice = {1'b0, r_a[int'(r_cnt)*CHUNK +: CHUNK]}
            + {1'b0, r_b[int'(r_cnt)*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, r_carry};
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = ADD;
      ADD:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_carry <= w_c_init;
      r_cnt   <= '0;
    end else if (r_state == ADD) begin
      r_sum[int'(r_cnt)*CHUNK +: CHUNK] <= w_slice[CHUNK-1:0];
      r_carry                           <= w_slice[CHUNK];
      r_cnt                             <= r_cnt + 1'b1;
      if (w_last) r_sum[WIDTH] <= w_slice[CHUNK];
    end
  end

endmodule

// File: tb/tb_rca_seq.sv
// Directed bench for rca_seq (WIDTH=16, CHUNK=4); builds the subtract checks when RCA_SEQ_SUB_EN is defined.
module tb_rca_seq;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c_in = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH:0]   sum;
  logic             busy;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  rca_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef RCA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Present operands at a falling edge, let the next rising edge accept them.
  task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc, input logic ts);
    a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  // Count edges after acceptance until out_valid; bounded so a dead DUT still ends.
  task automatic wait_result(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
  endtask

  task automatic handshake_idle(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ov_low"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    logic [WIDTH:0] held;

    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sum", {15'b0, sum}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full carry chain
    accept(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_result(n);
    chk("chain_latency", n, NCHUNK);
    chk("chain_sum", {15'b0, sum}, 32'h10000);
    handshake_idle("chain");

    // Single boundary carry, then carry-in
    accept(16'h0FFF, 16'h0001, 1'b0, 1'b0);
    wait_result(n);
    chk("bnd_sum", {15'b0, sum}, 32'h01000);
    handshake_idle("bnd");
    accept(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_result(n);
    chk("cin_latency", n, NCHUNK);
    chk("cin_sum", {15'b0, sum}, 32'h05556);
    handshake_idle("cin");

    // Backpressure: result held, new operands refused
    out_ready = 1'b0;
    accept(16'h00FF, 16'h0F01, 1'b0, 1'b0);
    wait_result(n);
    chk("bp_sum", {15'b0, sum}, 32'h01000);
    held = sum;
    a = 16'h7000; b = 16'h9000; c_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_ov_held", {31'b0, out_valid}, 32'd1);
      chk("bp_sum_held", {15'b0, sum}, {15'b0, held});
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    handshake_idle("bp");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_busy", {31'b0, busy}, 32'd1);
    wait_result(n);
    chk("bp_next_latency", n, NCHUNK);
    chk("bp_next_sum", {15'b0, sum}, 32'h10001);
    handshake_idle("bp_next");

    // Asynchronous reset two slices into an operation
    accept(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_sum", {15'b0, sum}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_result(n);
    chk("post_rst_sum", {15'b0, sum}, 32'h00003);
    handshake_idle("post_rst");

    // Inputs wiggle during ADD; latched operands must win
    accept(16'h8000, 16'h8000, 1'b0, 1'b0);
    for (int i = 0; i < NCHUNK; i++) begin
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    chk("stab_ov", {31'b0, out_valid}, 32'd1);
    chk("stab_sum", {15'b0, sum}, 32'h10000);
    handshake_idle("stab");

`ifdef RCA_SEQ_SUB_EN
    accept(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_result(n);
    chk("sub_borrow", {15'b0, sum}, 32'h0FFFE);
    handshake_idle("sub_borrow");
    accept(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_result(n);
    chk("sub_noborrow", {15'b0, sum}, 32'h10002);
    handshake_idle("sub_noborrow");
    accept(16'h0007, 16'h0005, 1'b0, 1'b0);
    wait_result(n);
    chk("sub0_add", {15'b0, sum}, 32'h0000C);
    handshake_idle("sub0_add");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/rca_seq.md
Name: rca_seq

Overview:
- Parametrised, multi-cycle successor to the 4-bit ripple-carry adder.
- Adds two WIDTH-bit operands plus carry-in, one CHUNK-bit ripple slice per clock, with the carry registered between slices.
- Gives wide datapaths a short critical path at the cost of WIDTH/CHUNK cycles of latency.
- Sits between a valid/ready producer and consumer; operands and result are fully registered.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle (ripple slice width); 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam: slices per operation.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH+1  result; sum[WIDTH] is carry-out.
- busy  output  1  high in ADD state.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, internal carry=0, chunk counter=0. Takes effect immediately, including mid-operation; the in-flight operation is discarded.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On edge with in_valid&&in_ready: latch a, b, c_in into operand regs; carry=c_in; counter=0; go to ADD.
  - Inputs are otherwise ignored.
- ADD:
  - in_ready=0, busy=1.
  - Each edge adds slice k = counter: {cy, s} = a_r[k*CHUNK +: CHUNK] + b_r[k*CHUNK +: CHUNK] + carry.
  - Writes s into sum[k*CHUNK +: CHUNK] and cy into carry; counter increments.
  - On the edge processing k=NCHUNK-1, sum[WIDTH] is also written with cy, and the FSM goes to DONE.
- DONE:
  - out_valid=1; sum held stable.
  - On edge with out_ready: out_valid=0, go to IDLE.
  - No new operands are accepted in the same cycle (in_ready=0 in DONE).
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. Throughput: one result per NCHUNK+2 cycles when out_ready is held high.
- Operands are sampled only at acceptance; later changes on a/b/c_in have no effect.
- sum bits of slices not yet processed retain their previous value during ADD. Consumers must use sum only while out_valid=1.
- Arithmetic is unsigned modulo 2^(WIDTH+1); no overflow flag.
- CHUNK=WIDTH degenerates to a single-cycle add (NCHUNK=1, latency 1).
- in_valid is ignored while out_valid=1 or busy=1. It is not an error; the producer holds it.

Optional Feature:
- Macro: RCA_SEQ_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - sub=1: the latched b is replaced by ~b and the initial carry is forced to 1, so sum = a + ~b + 1 = a - b (mod 2^WIDTH). c_in is ignored.
  - sum[WIDTH]=1 means no borrow (a >= b); sum[WIDTH]=0 means borrow.
  - sub=0 behaves exactly as the base block.
- When undefined: no sub port; add only.

Test Plan (WIDTH=16, CHUNK=4):
- Full carry chain: a=16'hFFFF, b=16'h0001, c_in=0, out_ready=1 -> out_valid exactly 4 cycles after accept, sum=17'h10000, then back to IDLE with in_ready=1.
- Carry across one slice boundary plus carry-in: a=16'h0FFF, b=16'h0001, c_in=0 -> sum=17'h01000. Then a=16'h1234, b=16'h4321, c_in=1 -> sum=17'h05556.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and sum held stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> one-cycle handshake, then accept the next operands.
- Reset mid-operation: accept a=16'hAAAA, b=16'h5555; assert rst_n=0 after 2 ADD cycles, asynchronously between edges -> outputs go to reset values immediately. After release, a=16'h0001, b=16'h0002 -> sum=17'h00003 with no residue.
- Operand stability: change a/b every cycle during ADD after accepting a=16'h8000, b=16'h8000 -> sum=17'h10000.
- With RCA_SEQ_SUB_EN: sub=1, a=16'h0005, b=16'h0007 -> sum=17'h0FFFE (borrow). sub=1, a=16'h0007, b=16'h0005 -> sum=17'h10002.
